// File: rtl/hazard_scoreboard_ctrl_if.sv
// Bundle of the decode-side hazard/bypass signals shared by the pipeline and the
// scoreboard controller. The master drives the pipeline view and the slave answers it.
interface hazard_scoreboard_ctrl_if #(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int REG_W   = 5,
    parameter int SEL_W   = $clog2(NUM_FWD + 2)
);
    // Decode operands and the instruction being issued
    logic                       dec_valid;
    logic [NUM_SRC-1:0]         src_used;
    logic [NUM_SRC*REG_W-1:0]   src_addr;
    logic                       iss_long;
    logic [REG_W-1:0]           iss_rd;

    // In-flight pipeline stages (index 0 is the youngest) and the long-latency completion bus
    logic [NUM_FWD-1:0]         fwd_wen;
    logic [NUM_FWD*REG_W-1:0]   fwd_addr;
    logic [NUM_FWD-1:0]         fwd_ready;
    logic                       cmpl_valid;
    logic [REG_W-1:0]           cmpl_addr;

    // Controller answers
    logic [NUM_SRC*SEL_W-1:0]   bypass_sel;
    logic                       stall;
    logic [(2**REG_W)-1:0]      busy_vec;
    logic [REG_W:0]             pending_cnt;
    logic [31:0]                stall_cycles;
    logic                       err_spurious;

    modport master (
        output dec_valid, src_used, src_addr, iss_long, iss_rd,
        output fwd_wen, fwd_addr, fwd_ready, cmpl_valid, cmpl_addr,
        input  bypass_sel, stall, busy_vec, pending_cnt, stall_cycles, err_spurious
    );

    modport slave (
        input  dec_valid, src_used, src_addr, iss_long, iss_rd,
        input  fwd_wen, fwd_addr, fwd_ready, cmpl_valid, cmpl_addr,
        output bypass_sel, stall, busy_vec, pending_cnt, stall_cycles, err_spurious
    );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// Decode-side hazard/bypass controller: picks an operand source per decode operand,
// tracks outstanding long-latency writebacks in a per-register scoreboard, and stalls on RAW/WAW.
module hazard_scoreboard_ctrl #(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int REG_W   = 5,
    parameter int SEL_W   = $clog2(NUM_FWD + 2)
) (
    input  logic clk,
    input  logic rst,
    hazard_scoreboard_ctrl_if.slave bus
);
    localparam int NREG = 2**REG_W;
    localparam logic [SEL_W-1:0] SEL_RF   = '0;
    localparam logic [SEL_W-1:0] SEL_CMPL = SEL_W'(NUM_FWD + 1);

    logic [NREG-1:0]    r_busy;
    logic [REG_W:0]     r_pending;
    logic [31:0]        r_stall_cycles;
    logic               r_err_spurious;

    logic [NUM_SRC-1:0] w_hazard;
    logic               w_waw;
    logic               w_stall;
    logic               w_set;
    logic               w_clr;
    logic               w_spurious;
    logic [NREG-1:0]    w_set_mask;
    logic [NREG-1:0]    w_clr_mask;
    logic [NREG-1:0]    w_busy_next;
    logic [REG_W:0]     w_pending_next;

    // Per-operand source resolution; purely combinational so decode sees it the same cycle.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_W-1:0] w_addr;
            logic             w_fwd_hit;
            logic             w_fwd_rdy;
            logic [SEL_W-1:0] w_fwd_sel;
            logic             w_cmpl_hit;
            logic [SEL_W-1:0] w_sel;
            logic             w_hz;

            assign w_addr     = bus.src_addr[gi*REG_W +: REG_W];
            assign w_cmpl_hit = bus.cmpl_valid && (bus.cmpl_addr == w_addr);

            // Scan oldest to youngest so the youngest matching writer is the one left standing
            always_comb begin
                w_fwd_hit = 1'b0;
                w_fwd_rdy = 1'b0;
                w_fwd_sel = SEL_RF;
                for (int k = NUM_FWD - 1; k >= 0; k--) begin
                    if (bus.fwd_wen[k] && (bus.fwd_addr[k*REG_W +: REG_W] == w_addr)) begin
                        w_fwd_hit = 1'b1;
                        w_fwd_rdy = bus.fwd_ready[k];
                        w_fwd_sel = SEL_W'(k + 1);
                    end
                end
            end

            always_comb begin
                w_sel = SEL_RF;
                w_hz  = 1'b0;
                if (bus.src_used[gi] && (w_addr != '0)) begin
                    if (w_fwd_hit) begin
                        if (w_fwd_rdy) begin
                            w_sel = w_fwd_sel;
                        end else begin
                            w_hz = 1'b1;
                        end
                    end else if (w_cmpl_hit) begin
                        w_sel = SEL_CMPL;
                    end else if (r_busy[w_addr]) begin
                        w_hz = 1'b1;
                    end
                end
            end

            assign bus.bypass_sel[gi*SEL_W +: SEL_W] = w_sel;
            assign w_hazard[gi]                      = w_hz;
        end
    endgenerate

    // A rewrite of a busy register may proceed only when its completion lands this cycle.
    assign w_waw = bus.iss_long && (bus.iss_rd != '0) && r_busy[bus.iss_rd]
                   && !(bus.cmpl_valid && (bus.cmpl_addr == bus.iss_rd));

    assign w_stall = bus.dec_valid && ((|w_hazard) || w_waw);

    assign w_set      = bus.dec_valid && !w_stall && bus.iss_long && (bus.iss_rd != '0);
    assign w_clr      = bus.cmpl_valid && r_busy[bus.cmpl_addr];
    assign w_spurious = bus.cmpl_valid && (bus.cmpl_addr != '0) && !r_busy[bus.cmpl_addr];

    assign w_set_mask = w_set ? (NREG'(1) << bus.iss_rd)    : '0;
    assign w_clr_mask = w_clr ? (NREG'(1) << bus.cmpl_addr) : '0;

    // Set is applied after clear so a same-register set/clear leaves the bit held.
    assign w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;

    always_comb begin
        w_pending_next = r_pending;
        case ({w_set, w_clr})
            2'b10:   w_pending_next = r_pending + (REG_W+1)'(1);
            2'b01:   w_pending_next = r_pending - (REG_W+1)'(1);
            default: w_pending_next = r_pending;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy         <= '0;
            r_pending      <= '0;
            r_stall_cycles <= '0;
            r_err_spurious <= 1'b0;
        end else begin
            r_busy    <= w_busy_next;
            r_pending <= w_pending_next;
            if (w_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_spurious) begin
                r_err_spurious <= 1'b1;
            end
        end
    end

    assign bus.stall        = w_stall;
    assign bus.busy_vec     = r_busy;
    assign bus.pending_cnt  = r_pending;
    assign bus.stall_cycles = r_stall_cycles;
    assign bus.err_spurious = r_err_spurious;

    // The incremental counter must track the scoreboard population exactly; r0 is never tracked.
    a_pending_popcount: assert property (@(posedge clk) disable iff (rst)
        r_pending == (REG_W+1)'($countones(r_busy)));
    a_r0_never_busy: assert property (@(posedge clk) disable iff (rst) !r_busy[0]);

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Scoreboard-driven bench for hazard_scoreboard_ctrl: expectations are queued as stimulus is
// applied and drained against the DUT when the combinational and registered outputs are valid.
module tb_hazard_scoreboard_ctrl;
    localparam int NUM_SRC = 2;
    localparam int NUM_FWD = 2;
    localparam int REG_W   = 5;
    localparam int SEL_W   = $clog2(NUM_FWD + 2);
    localparam int NREG    = 1 << REG_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_ctrl_if #(
        .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .REG_W(REG_W), .SEL_W(SEL_W)
    ) bus ();

    hazard_scoreboard_ctrl #(
        .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .REG_W(REG_W), .SEL_W(SEL_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum int {K_SEL0, K_SEL1, K_STALL, K_BUSY, K_PEND, K_SCNT, K_ERR} kind_e;
    typedef struct {
        kind_e       kind;
        logic [63:0] value;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [NREG-1:0] m_busy;
    logic [31:0]     m_scnt;
    logic            m_err;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] observe(input kind_e k);
        logic [63:0] v;
        v = '0;
        case (k)
            K_SEL0:  v = 64'(bus.bypass_sel[SEL_W-1:0]);
            K_SEL1:  v = 64'(bus.bypass_sel[2*SEL_W-1:SEL_W]);
            K_STALL: v = 64'(bus.stall);
            K_BUSY:  v = 64'(bus.busy_vec);
            K_PEND:  v = 64'(bus.pending_cnt);
            K_SCNT:  v = 64'(bus.stall_cycles);
            K_ERR:   v = 64'(bus.err_spurious);
            default: v = '1;
        endcase
        return v;
    endfunction

    task automatic push_exp(input kind_e k, input logic [63:0] v, input string tag);
        exp_t e;
        e.kind  = k;
        e.value = v;
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val(e.tag, observe(e.kind), e.value);
        end
    endtask

    task automatic push_state(input string tag);
        push_exp(K_BUSY, 64'(m_busy),             {tag, ".busy"});
        push_exp(K_PEND, 64'($countones(m_busy)), {tag, ".pend"});
        push_exp(K_SCNT, 64'(m_scnt),             {tag, ".scnt"});
        push_exp(K_ERR,  64'(m_err),              {tag, ".err"});
    endtask

    task automatic idle();
        bus.dec_valid  = 1'b0;
        bus.src_used   = '0;
        bus.src_addr   = '0;
        bus.iss_long   = 1'b0;
        bus.iss_rd     = '0;
        bus.fwd_wen    = '0;
        bus.fwd_addr   = '0;
        bus.fwd_ready  = '0;
        bus.cmpl_valid = 1'b0;
        bus.cmpl_addr  = '0;
    endtask

    // One decode cycle: check same-cycle outputs at the falling edge, advance the reference
    // scoreboard from the applied stimulus and the expected stall, then check registered state.
    task automatic cycle(input string tag, input logic [SEL_W-1:0] e_sel0,
                         input logic [SEL_W-1:0] e_sel1, input logic e_stall);
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] ca;
        logic             set;
        logic             clr;
        push_exp(K_SEL0,  64'(e_sel0),  {tag, ".sel0"});
        push_exp(K_SEL1,  64'(e_sel1),  {tag, ".sel1"});
        push_exp(K_STALL, 64'(e_stall), {tag, ".stall"});
        @(negedge clk);
        drain();
        rd  = bus.iss_rd;
        ca  = bus.cmpl_addr;
        set = bus.dec_valid && !e_stall && bus.iss_long && (rd != '0);
        clr = bus.cmpl_valid && m_busy[ca];
        if (bus.cmpl_valid && (ca != '0) && !m_busy[ca]) m_err = 1'b1;
        if (clr) m_busy[ca] = 1'b0;
        if (set) m_busy[rd] = 1'b1;
        if (e_stall) m_scnt = m_scnt + 32'd1;
        @(posedge clk);
        #1;
        push_state(tag);
        drain();
        $display("[%0t] %s: sel=%0h stall=%0b busy=%08h pend=%0d scnt=%0d err=%0b", $time, tag,
                 bus.bypass_sel, bus.stall, bus.busy_vec, bus.pending_cnt, bus.stall_cycles,
                 bus.err_spurious);
    endtask

    int ord[NREG-1];

    initial begin
        idle();
        m_busy = '0;
        m_scnt = '0;
        m_err  = 1'b0;

        // Held in reset: everything quiet
        repeat (2) @(posedge clk);
        #1;
        push_exp(K_SEL0,  64'd0, "reset.sel0");
        push_exp(K_SEL1,  64'd0, "reset.sel1");
        push_exp(K_STALL, 64'd0, "reset.stall");
        push_state("reset");
        drain();
        rst = 1'b0;

        // Youngest matching stage wins; a not-ready youngest stalls even if an older one is ready
        bus.dec_valid = 1'b1;
        bus.src_used  = 2'b01;
        bus.src_addr  = {5'd0, 5'd3};
        bus.fwd_wen   = 2'b11;
        bus.fwd_addr  = {5'd3, 5'd3};
        bus.fwd_ready = 2'b01;
        cycle("fwd_young", 2'd1, 2'd0, 1'b0);
        bus.fwd_ready = 2'b10;
        cycle("fwd_young_notready", 2'd0, 2'd0, 1'b1);

        // Operand 1: pipeline forward beats scoreboard, then busy stalls, then completion bus
        idle();
        bus.dec_valid = 1'b1;
        bus.iss_long  = 1'b1;
        bus.iss_rd    = 5'd20;
        cycle("iss_r20", 2'd0, 2'd0, 1'b0);
        idle();
        bus.dec_valid = 1'b1;
        bus.src_used  = 2'b10;
        bus.src_addr  = {5'd20, 5'd0};
        bus.fwd_wen   = 2'b10;
        bus.fwd_addr  = {5'd20, 5'd0};
        bus.fwd_ready = 2'b10;
        cycle("fwd_stage1_r20", 2'd0, 2'd2, 1'b0);
        bus.fwd_wen = 2'b00;
        cycle("busy_r20", 2'd0, 2'd0, 1'b1);
        bus.cmpl_valid = 1'b1;
        bus.cmpl_addr  = 5'd20;
        cycle("cmpl_r20", 2'd0, 2'd3, 1'b0);

        // Long op to r5, dependent consumer waits, then takes the completion bus
        idle();
        bus.dec_valid = 1'b1;
        bus.iss_long  = 1'b1;
        bus.iss_rd    = 5'd5;
        cycle("iss_r5", 2'd0, 2'd0, 1'b0);
        idle();
        bus.dec_valid = 1'b1;
        bus.src_used  = 2'b01;
        bus.src_addr  = {5'd0, 5'd5};
        for (int i = 0; i < 4; i++) cycle("wait_r5", 2'd0, 2'd0, 1'b1);
        bus.cmpl_valid = 1'b1;
        bus.cmpl_addr  = 5'd5;
        cycle("cmpl_r5", 2'd3, 2'd0, 1'b0);

        // WAW on r7, released by a same-cycle completion that leaves the bit set
        idle();
        bus.dec_valid = 1'b1;
        bus.iss_long  = 1'b1;
        bus.iss_rd    = 5'd7;
        cycle("iss_r7", 2'd0, 2'd0, 1'b0);
        cycle("waw_r7", 2'd0, 2'd0, 1'b1);
        bus.cmpl_valid = 1'b1;
        bus.cmpl_addr  = 5'd7;
        cycle("waw_cmpl_r7", 2'd0, 2'd0, 1'b0);
        idle();
        bus.cmpl_valid = 1'b1;
        bus.cmpl_addr  = 5'd7;
        cycle("cmpl_r7", 2'd0, 2'd0, 1'b0);

        // r0 is never a hazard and never tracked
        idle();
        bus.dec_valid = 1'b1;
        bus.src_used  = 2'b11;
        bus.src_addr  = '0;
        bus.fwd_wen   = 2'b11;
        bus.fwd_addr  = '0;
        bus.fwd_ready = 2'b00;
        bus.iss_long  = 1'b1;
        bus.iss_rd    = 5'd0;
        cycle("r0", 2'd0, 2'd0, 1'b0);

        // Spurious completion is sticky; reset mid-cycle clears everything at once
        idle();
        bus.cmpl_valid = 1'b1;
        bus.cmpl_addr  = 5'd9;
        cycle("spur_r9", 2'd0, 2'd0, 1'b0);
        idle();
        cycle("spur_sticky", 2'd0, 2'd0, 1'b0);
        bus.dec_valid = 1'b1;
        bus.iss_long  = 1'b1;
        bus.iss_rd    = 5'd12;
        cycle("iss_r12", 2'd0, 2'd0, 1'b0);
        idle();
        #3;
        rst = 1'b1;
        #1;
        m_busy = '0;
        m_scnt = '0;
        m_err  = 1'b0;
        push_exp(K_STALL, 64'd0, "async_rst.stall");
        push_state("async_rst");
        drain();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill r1..r31, then retire them in a shuffled order
        for (int r = 1; r < NREG; r++) begin
            idle();
            bus.dec_valid = 1'b1;
            bus.iss_long  = 1'b1;
            bus.iss_rd    = REG_W'(r);
            cycle($sformatf("fill_r%0d", r), 2'd0, 2'd0, 1'b0);
        end
        push_exp(K_PEND, 64'd31, "full.pend");
        push_exp(K_BUSY, 64'hFFFF_FFFE, "full.busy");
        drain();
        for (int i = 0; i < NREG - 1; i++) ord[i] = i + 1;
        for (int i = NREG - 2; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = ord[i];
            ord[i] = ord[j];
            ord[j] = t;
        end
        for (int i = 0; i < NREG - 1; i++) begin
            idle();
            bus.cmpl_valid = 1'b1;
            bus.cmpl_addr  = REG_W'(ord[i]);
            cycle($sformatf("drain_r%0d", ord[i]), 2'd0, 2'd0, 1'b0);
        end
        idle();
        push_exp(K_PEND, 64'd0, "empty.pend");
        push_exp(K_BUSY, 64'd0, "empty.busy");
        push_exp(K_ERR,  64'd0, "empty.err");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
